// File: rtl/kg_regfile_pkg.sv
// Shared definitions for the Kugelblitz offload control register file.
// Holds the register byte offsets, the AXI response code and the FSM state
// encodings. State values are chosen so each handshake output is one state bit.
package kg_regfile_pkg;

    localparam int unsigned NUM_REGS = 4;

    localparam logic [7:0] KG_REG_ADDR       = 8'h00;
    localparam logic [7:0] KG_REG_ADDR_VALID = 8'h04;
    localparam logic [7:0] KG_REG_DATA       = 8'h08;
    localparam logic [7:0] KG_REG_DATA_VALID = 8'h0C;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // bit 0 = address ready, bit 1 = response/data valid
    typedef enum logic [1:0] {
        WR_IDLE   = 2'b00,
        WR_ACCEPT = 2'b01,
        WR_RESP   = 2'b10
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'b00,
        RD_ACCEPT = 2'b01,
        RD_DATA   = 2'b10
    } rd_state_t;

    // Word index of a register byte offset.
    function automatic logic [1:0] reg_index(input logic [7:0] offset);
        return offset[3:2];
    endfunction

endpackage

// File: rtl/axil_kg_regfile.sv
// AXI4-Lite slave holding the Kugelblitz offload control words.
// Four registers (address/selector, address-valid, data byte, data-valid) are
// driven continuously onto kg_* sideband outputs for the streaming logic.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   s_axil_aw*/w*/b*    AXI-Lite write channels (AW and W accepted together)
//   s_axil_ar*/r*       AXI-Lite read channels
//   kg_address          REG_ADDR contents
//   kg_address_valid    REG_ADDR_VALID contents (bit 0 used downstream)
//   kg_data             REG_DATA contents (bits [7:0] used downstream)
//   kg_data_valid       REG_DATA_VALID contents
module axil_kg_regfile
    import kg_regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,

    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,

    output logic [DATA_WIDTH-1:0] kg_address,
    output logic [DATA_WIDTH-1:0] kg_address_valid,
    output logic [DATA_WIDTH-1:0] kg_data,
    output logic [DATA_WIDTH-1:0] kg_data_valid
);

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] rdata_q;

    logic       wr_fire_c;
    logic       rd_fire_c;
    logic       wr_in_range_c;
    logic       rd_in_range_c;
    logic [1:0] wr_idx_c;
    logic [1:0] rd_idx_c;

    // Protection bits and byte-lane address bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{s_axil_awprot, s_axil_arprot,
                             s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    // Address decode: anything with a bit set at or above bit 4 is out of range.
    assign wr_in_range_c = ~|s_axil_awaddr[ADDR_WIDTH-1:4];
    assign rd_in_range_c = ~|s_axil_araddr[ADDR_WIDTH-1:4];
    assign wr_idx_c      = s_axil_awaddr[3:2];
    assign rd_idx_c      = s_axil_araddr[3:2];

    assign wr_fire_c = (wr_state == WR_ACCEPT) && s_axil_awvalid && s_axil_wvalid;
    assign rd_fire_c = (rd_state == RD_ACCEPT) && s_axil_arvalid;

    // Write FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= WR_IDLE;
        end else begin
            wr_state <= wr_next;
        end
    end

    // Write FSM next state; AW and W must both be valid before accepting.
    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE:   if (s_axil_awvalid && s_axil_wvalid) wr_next = WR_ACCEPT;
            WR_ACCEPT: wr_next = wr_fire_c ? WR_RESP : WR_IDLE;
            WR_RESP:   if (s_axil_bready) wr_next = WR_IDLE;
            default:   wr_next = WR_IDLE;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= RD_IDLE;
        end else begin
            rd_state <= rd_next;
        end
    end

    // Read FSM next state; one read outstanding at a time.
    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE:   if (s_axil_arvalid) rd_next = RD_ACCEPT;
            RD_ACCEPT: rd_next = rd_fire_c ? RD_DATA : RD_IDLE;
            RD_DATA:   if (s_axil_rready) rd_next = RD_IDLE;
            default:   rd_next = RD_IDLE;
        endcase
    end

    // Register array with byte-granular writes; out-of-range writes are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_fire_c && wr_in_range_c) begin
            for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
                if (s_axil_wstrb[b]) begin
                    regs[wr_idx_c][b*8 +: 8] <= s_axil_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read data capture; sees the pre-write value on a coincident write edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_fire_c) begin
            rdata_q <= rd_in_range_c ? regs[rd_idx_c] : '0;
        end
    end

    assign s_axil_awready = wr_state[0];
    assign s_axil_wready  = wr_state[0];
    assign s_axil_bvalid  = wr_state[1];
    assign s_axil_bresp   = RESP_OKAY;

    assign s_axil_arready = rd_state[0];
    assign s_axil_rvalid  = rd_state[1];
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = RESP_OKAY;

    assign kg_address       = regs[reg_index(KG_REG_ADDR)];
    assign kg_address_valid = regs[reg_index(KG_REG_ADDR_VALID)];
    assign kg_data          = regs[reg_index(KG_REG_DATA)];
    assign kg_data_valid    = regs[reg_index(KG_REG_DATA_VALID)];

endmodule

// File: tb/tb_axil_kg_regfile.sv
// Directed bench for axil_kg_regfile: a small register model predicts kg_*
// outputs, and expected read data is queued when a read is issued and popped
// when rvalid appears.
module tb_axil_kg_regfile;
    import kg_regfile_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] s_axil_awaddr;
    logic [2:0]    s_axil_awprot;
    logic          s_axil_awvalid;
    logic          s_axil_awready;
    logic [DW-1:0] s_axil_wdata;
    logic [SW-1:0] s_axil_wstrb;
    logic          s_axil_wvalid;
    logic          s_axil_wready;
    logic [1:0]    s_axil_bresp;
    logic          s_axil_bvalid;
    logic          s_axil_bready;
    logic [AW-1:0] s_axil_araddr;
    logic [2:0]    s_axil_arprot;
    logic          s_axil_arvalid;
    logic          s_axil_arready;
    logic [DW-1:0] s_axil_rdata;
    logic [1:0]    s_axil_rresp;
    logic          s_axil_rvalid;
    logic          s_axil_rready;
    logic [DW-1:0] kg_address;
    logic [DW-1:0] kg_address_valid;
    logic [DW-1:0] kg_data;
    logic [DW-1:0] kg_data_valid;

    int n_cmp = 0;
    int n_mis = 0;

    logic [DW-1:0] mdl [4];
    logic [DW-1:0] exp_q [$];

    axil_kg_regfile #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .STRB_WIDTH(SW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_axil_awaddr    (s_axil_awaddr),
        .s_axil_awprot    (s_axil_awprot),
        .s_axil_awvalid   (s_axil_awvalid),
        .s_axil_awready   (s_axil_awready),
        .s_axil_wdata     (s_axil_wdata),
        .s_axil_wstrb     (s_axil_wstrb),
        .s_axil_wvalid    (s_axil_wvalid),
        .s_axil_wready    (s_axil_wready),
        .s_axil_bresp     (s_axil_bresp),
        .s_axil_bvalid    (s_axil_bvalid),
        .s_axil_bready    (s_axil_bready),
        .s_axil_araddr    (s_axil_araddr),
        .s_axil_arprot    (s_axil_arprot),
        .s_axil_arvalid   (s_axil_arvalid),
        .s_axil_arready   (s_axil_arready),
        .s_axil_rdata     (s_axil_rdata),
        .s_axil_rresp     (s_axil_rresp),
        .s_axil_rvalid    (s_axil_rvalid),
        .s_axil_rready    (s_axil_rready),
        .kg_address       (kg_address),
        .kg_address_valid (kg_address_valid),
        .kg_data          (kg_data),
        .kg_data_valid    (kg_data_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mdl_read(input logic [AW-1:0] addr);
        if (addr[AW-1:4] != '0) return '0;
        return mdl[addr[3:2]];
    endfunction

    task automatic mdl_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [SW-1:0] strb);
        if (addr[AW-1:4] == '0) begin
            for (int b = 0; b < int'(SW); b++) begin
                if (strb[b]) mdl[addr[3:2]][b*8 +: 8] = data[b*8 +: 8];
            end
        end
    endtask

    task automatic check_kg(input string tag);
        chk({tag, "_kg_address"},       kg_address,       mdl[0]);
        chk({tag, "_kg_address_valid"}, kg_address_valid, mdl[1]);
        chk({tag, "_kg_data"},          kg_data,          mdl[2]);
        chk({tag, "_kg_data_valid"},    kg_data_valid,    mdl[3]);
    endtask

    // Full write with bready held high; lat = edges from valid to bvalid.
    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [SW-1:0] strb, output int lat);
        int cyc = 0;
        s_axil_awaddr  = addr;
        s_axil_wdata   = data;
        s_axil_wstrb   = strb;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        while (!s_axil_awready && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("wr_awready", 32'(s_axil_awready), 32'd1);
        chk("wr_wready",  32'(s_axil_wready),  32'd1);
        tick();
        cyc++;
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        mdl_write(addr, data, strb);
        chk("wr_bvalid", 32'(s_axil_bvalid), 32'd1);
        chk("wr_bresp",  32'(s_axil_bresp),  32'(RESP_OKAY));
        check_kg("wr");
        lat = cyc;
        tick();
        chk("wr_bvalid_clear", 32'(s_axil_bvalid), 32'd0);
    endtask

    // Full read with rready held high; expectation queued at issue.
    task automatic do_read(input logic [AW-1:0] addr);
        int cyc = 0;
        exp_q.push_back(mdl_read(addr));
        s_axil_araddr  = addr;
        s_axil_arvalid = 1'b1;
        while (!s_axil_arready && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("rd_arready", 32'(s_axil_arready), 32'd1);
        tick();
        s_axil_arvalid = 1'b0;
        chk("rd_rvalid", 32'(s_axil_rvalid), 32'd1);
        if (exp_q.size() > 0) chk("rd_rdata", s_axil_rdata, exp_q.pop_front());
        chk("rd_rresp", 32'(s_axil_rresp), 32'(RESP_OKAY));
        tick();
        chk("rd_rvalid_clear", 32'(s_axil_rvalid), 32'd0);
    endtask

    initial begin
        int            lat;
        int            cyc;
        logic [DW-1:0] held;

        rst            = 1'b1;
        s_axil_awaddr  = '0;
        s_axil_awprot  = '0;
        s_axil_awvalid = 1'b0;
        s_axil_wdata   = '0;
        s_axil_wstrb   = '0;
        s_axil_wvalid  = 1'b0;
        s_axil_bready  = 1'b1;
        s_axil_araddr  = '0;
        s_axil_arprot  = '0;
        s_axil_arvalid = 1'b0;
        s_axil_rready  = 1'b1;
        for (int i = 0; i < 4; i++) mdl[i] = '0;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_awready", 32'(s_axil_awready), 32'd0);
        chk("rst_wready",  32'(s_axil_wready),  32'd0);
        chk("rst_bvalid",  32'(s_axil_bvalid),  32'd0);
        chk("rst_arready", 32'(s_axil_arready), 32'd0);
        chk("rst_rvalid",  32'(s_axil_rvalid),  32'd0);
        chk("rst_rdata",   s_axil_rdata,        32'd0);
        check_kg("rst");

        // Full write / readback
        do_write(32'(KG_REG_ADDR), 32'h0000_003C, 4'hF, lat);
        chk("wr_latency", 32'(lat), 32'd2);
        do_write(32'(KG_REG_ADDR_VALID), 32'h0000_0001, 4'hF, lat);
        do_write(32'(KG_REG_DATA), 32'h0000_00AA, 4'hF, lat);
        chk("full_kg_address", kg_address, 32'h0000_003C);
        chk("full_kg_address_valid", kg_address_valid, 32'h0000_0001);
        chk("full_kg_data", kg_data, 32'h0000_00AA);
        do_read(32'(KG_REG_ADDR));
        do_read(32'(KG_REG_ADDR_VALID));
        do_read(32'(KG_REG_DATA));

        // Byte strobes
        do_write(32'(KG_REG_DATA), 32'h1122_3344, 4'hF, lat);
        do_write(32'(KG_REG_DATA), 32'hAABB_CCDD, 4'b0101, lat);
        chk("strb_0101", kg_data, 32'h11BB_33DD);
        do_write(32'(KG_REG_DATA), 32'hFFFF_FFFF, 4'b0000, lat);
        chk("strb_0000", kg_data, 32'h11BB_33DD);
        do_read(32'h0000_000B);

        // Write backpressure: bvalid holds and a second write waits
        s_axil_bready  = 1'b0;
        s_axil_awaddr  = 32'(KG_REG_DATA_VALID);
        s_axil_wdata   = 32'h0000_0005;
        s_axil_wstrb   = 4'hF;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        cyc = 0;
        while (!s_axil_awready && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("bp_awready", 32'(s_axil_awready), 32'd1);
        tick();
        mdl_write(32'(KG_REG_DATA_VALID), 32'h0000_0005, 4'hF);
        chk("bp_bvalid", 32'(s_axil_bvalid), 32'd1);
        s_axil_awaddr = 32'(KG_REG_ADDR);
        s_axil_wdata  = 32'h0000_0077;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_bvalid_hold", 32'(s_axil_bvalid), 32'd1);
            chk("bp_no_accept", 32'(s_axil_awready), 32'd0);
        end
        check_kg("bp_hold");
        s_axil_bready = 1'b1;
        tick();
        chk("bp_bvalid_release", 32'(s_axil_bvalid), 32'd0);
        do_write(32'(KG_REG_ADDR), 32'h0000_0077, 4'hF, lat);

        // Read backpressure: rvalid/rdata hold and a second read waits
        s_axil_rready = 1'b0;
        exp_q.push_back(mdl_read(32'(KG_REG_DATA_VALID)));
        s_axil_araddr  = 32'(KG_REG_DATA_VALID);
        s_axil_arvalid = 1'b1;
        cyc = 0;
        while (!s_axil_arready && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("rbp_arready", 32'(s_axil_arready), 32'd1);
        tick();
        s_axil_araddr = 32'(KG_REG_ADDR);
        chk("rbp_rvalid", 32'(s_axil_rvalid), 32'd1);
        held = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk("rbp_rdata", s_axil_rdata, held);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rbp_rvalid_hold", 32'(s_axil_rvalid), 32'd1);
            chk("rbp_rdata_hold", s_axil_rdata, held);
            chk("rbp_no_accept", 32'(s_axil_arready), 32'd0);
        end
        s_axil_rready = 1'b1;
        tick();
        chk("rbp_rvalid_release", 32'(s_axil_rvalid), 32'd0);
        do_read(32'(KG_REG_ADDR));

        // Split channels: lone awvalid waits for wvalid
        s_axil_awaddr  = 32'(KG_REG_ADDR_VALID);
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("split_awready", 32'(s_axil_awready), 32'd0);
        end
        do_write(32'(KG_REG_ADDR_VALID), 32'h0000_0002, 4'hF, lat);
        do_read(32'(KG_REG_ADDR_VALID));

        // Asynchronous reset mid-write
        s_axil_awaddr  = 32'(KG_REG_ADDR);
        s_axil_wdata   = 32'h0000_DEAD;
        s_axil_wstrb   = 4'hF;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        cyc = 0;
        while (!s_axil_awready && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("mid_awready", 32'(s_axil_awready), 32'd1);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) mdl[i] = '0;
        chk("mid_rst_awready", 32'(s_axil_awready), 32'd0);
        chk("mid_rst_bvalid",  32'(s_axil_bvalid),  32'd0);
        chk("mid_rst_rvalid",  32'(s_axil_rvalid),  32'd0);
        check_kg("mid_rst");
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("mid_rst_no_resp", 32'(s_axil_bvalid), 32'd0);
        do_read(32'(KG_REG_ADDR));

        // Out-of-range access
        do_write(32'(KG_REG_ADDR), 32'h0000_003C, 4'hF, lat);
        do_write(32'(KG_REG_DATA), 32'h0000_00AA, 4'hF, lat);
        do_write(32'h0000_0010, 32'hFFFF_FFFF, 4'hF, lat);
        chk("oor_kg_data", kg_data, 32'h0000_00AA);
        do_read(32'h0000_0010);

        // Simultaneous read and write of REG_DATA
        exp_q.push_back(mdl_read(32'(KG_REG_DATA)));
        s_axil_awaddr  = 32'(KG_REG_DATA);
        s_axil_wdata   = 32'h0000_0055;
        s_axil_wstrb   = 4'hF;
        s_axil_araddr  = 32'(KG_REG_DATA);
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        s_axil_arvalid = 1'b1;
        cyc = 0;
        while (!(s_axil_awready && s_axil_arready) && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("sim_ready", 32'(s_axil_awready && s_axil_arready), 32'd1);
        tick();
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        s_axil_arvalid = 1'b0;
        mdl_write(32'(KG_REG_DATA), 32'h0000_0055, 4'hF);
        chk("sim_bvalid", 32'(s_axil_bvalid), 32'd1);
        chk("sim_rvalid", 32'(s_axil_rvalid), 32'd1);
        if (exp_q.size() > 0) chk("sim_rdata_old", s_axil_rdata, exp_q.pop_front());
        chk("sim_rdata_const", s_axil_rdata, 32'h0000_00AA);
        check_kg("sim");
        tick();
        do_read(32'(KG_REG_DATA));

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
